factor_input_debouncer: RTL



---
 rtl/multiplier_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/factor_input_debouncer.sv | 104 ++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared constants and FSM encoding for the multiplier/display datapath.
package multiplier_pkg;

  localparam int FACTOR_W                = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 25;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } deb_state_t;

  // Qualification counter only needs to reach n-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins, clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/factor_input_debouncer.sv
// Synchronises and debounces the two factor switch banks as one vector.
// Optional glitch counter output: define FACTOR_DEBOUNCE_GLITCH_CNT_EN.
module factor_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = multiplier_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int FACTOR_W        = multiplier_pkg::FACTOR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FACTOR_W-1:0] i_factor_a,
  input  logic [FACTOR_W-1:0] i_factor_b,
  output logic [FACTOR_W-1:0] o_factor_a,
  output logic [FACTOR_W-1:0] o_factor_b,
  output logic                o_update,
  output logic                o_busy
`ifdef FACTOR_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [3:0]          o_glitch_cnt
`endif
);

  import multiplier_pkg::*;

  localparam int PW = 2 * FACTOR_W;
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [PW-1:0] pins;
  logic [PW-1:0] sync;
  logic [PW-1:0] cand;
  logic [PW-1:0] stable;
  logic [CW-1:0] cnt;
  deb_state_t    state;

  assign pins   = {i_factor_a, i_factor_b};
  assign stable = {o_factor_a, o_factor_b};

  sync_2ff #(
    .WIDTH(PW)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (pins),
    .q    (sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      o_factor_a <= '0;
      o_factor_b <= '0;
      o_update   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_update <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync != stable) begin
            cand   <= sync;
            cnt    <= '0;
            state  <= QUAL;
            o_busy <= 1'b1;
          end
        end
        QUAL: begin
          // Abandon beats restart beats accept.
          if (sync == stable) begin
            cnt    <= '0;
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
          end else if (cnt == LAST) begin
            {o_factor_a, o_factor_b} <= cand;
            o_update <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
            o_busy   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FACTOR_DEBOUNCE_GLITCH_CNT_EN
  logic glitch;

  assign glitch = (state == QUAL) &&
                  ((sync == stable) || (sync != cand));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_glitch_cnt <= '0;
    end else if (glitch && o_glitch_cnt != 4'd15) begin
      o_glitch_cnt <= o_glitch_cnt + 4'd1;
    end
  end
`endif

endmodule
